// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a 1-8 bit pattern MSB-first at CLK_DIV cycles per bit,
// with optional repeats separated by idle-zero gaps, and shows the completed-frame count on a 7-segment display.
`timescale 1ns/1ps
module seq_pattern_tx #(
    parameter int CLK_DIV  = 4,
    parameter int GAP_BITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic [7:0] pattern_i,
    input  logic [2:0] pat_len_i,
    input  logic [3:0] repeat_i,
    output logic       bit_out_o,
    output logic       bit_strobe_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] frame_cnt_o,
    output logic [7:0] seg_o
);

    localparam int GAP_CYC = GAP_BITS * CLK_DIV;
    localparam int CNT_MAX = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       idx_q,   idx_d;
    logic [2:0]       len_q,   len_d;
    logic [7:0]       pat_q,   pat_d;
    logic [3:0]       rep_q,   rep_d;
    logic             bit_q,   bit_d;
    logic             stb_q,   stb_d;
    logic             done_q,  done_d;
    logic [7:0]       fcnt_q,  fcnt_d;
    logic [7:0]       seg_q,   seg_d;

    // Digit codes keep the dot (bit 0) clear; the dot marks an active transmission.
    function automatic logic [7:0] seg_encode(input logic [7:0] cnt, input logic busy);
        logic [3:0] d;
        logic [7:0] code;
        d = 4'(cnt % 8'd10);
        case (d)
            4'd0:    code = 8'hFC;
            4'd1:    code = 8'hC0;
            4'd2:    code = 8'h6E;
            4'd3:    code = 8'hE6;
            4'd4:    code = 8'hD2;
            4'd5:    code = 8'hB6;
            4'd6:    code = 8'hBE;
            4'd7:    code = 8'hE0;
            4'd8:    code = 8'hFE;
            4'd9:    code = 8'hF6;
            default: code = 8'hFC;
        endcase
        if (!busy && cnt == 8'd0) begin
            code = 8'h02;
        end else begin
            code[0] = busy;
        end
        return code;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        pat_d   = pat_q;
        rep_d   = rep_q;
        bit_d   = bit_q;
        stb_d   = stb_q;
        done_d  = done_q;
        fcnt_d  = fcnt_q;
        seg_d   = seg_q;

        if (ena_i) begin
            stb_d  = 1'b0;
            done_d = 1'b0;
            seg_d  = seg_encode(fcnt_q, state_q != S_IDLE);

            unique case (state_q)
                S_IDLE: begin
                    bit_d = 1'b0;
                    if (start_i && !stop_i) begin
                        pat_d   = pattern_i;
                        len_d   = pat_len_i;
                        rep_d   = repeat_i;
                        idx_d   = pat_len_i;
                        cnt_d   = '0;
                        fcnt_d  = 8'd0;
                        bit_d   = pattern_i[pat_len_i];
                        stb_d   = 1'b1;
                        state_d = S_SEND;
                    end
                end

                S_SEND: begin
                    if (stop_i) begin
                        state_d = S_IDLE;
                        bit_d   = 1'b0;
                        cnt_d   = '0;
                    end else if (cnt_q != BIT_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (idx_q != 3'd0) begin
                        idx_d = idx_q - 3'd1;
                        cnt_d = '0;
                        bit_d = pat_q[idx_q - 3'd1];
                        stb_d = 1'b1;
                    end else begin
                        // Last bit of the frame has fully elapsed.
                        fcnt_d = fcnt_q + 8'd1;
                        cnt_d  = '0;
                        if (rep_q == 4'd1) begin
                            state_d = S_IDLE;
                            bit_d   = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            if (rep_q != 4'd0) begin
                                rep_d = rep_q - 4'd1;
                            end
                            if (GAP_BITS == 0) begin
                                idx_d = len_q;
                                bit_d = pat_q[len_q];
                                stb_d = 1'b1;
                            end else begin
                                state_d = S_GAP;
                                bit_d   = 1'b0;
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (stop_i) begin
                        state_d = S_IDLE;
                        bit_d   = 1'b0;
                        cnt_d   = '0;
                    end else if (cnt_q != GAP_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = S_SEND;
                        idx_d   = len_q;
                        cnt_d   = '0;
                        bit_d   = pat_q[len_q];
                        stb_d   = 1'b1;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    bit_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            len_q   <= 3'd0;
            pat_q   <= 8'd0;
            rep_q   <= 4'd0;
            bit_q   <= 1'b0;
            stb_q   <= 1'b0;
            done_q  <= 1'b0;
            fcnt_q  <= 8'd0;
            seg_q   <= 8'h02;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            bit_q   <= bit_d;
            stb_q   <= stb_d;
            done_q  <= done_d;
            fcnt_q  <= fcnt_d;
            seg_q   <= seg_d;
        end
    end

    // Pulses are held in their registers across an ena-low stretch but must not be seen while frozen.
    assign bit_strobe_o = stb_q & ena_i;
    assign done_o       = done_q & ena_i;
    assign bit_out_o    = bit_q;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_cnt_o  = fcnt_q;
    assign seg_o        = seg_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: per-cycle expected output trace queued at start, popped and compared each cycle.
`timescale 1ns/1ps
module tb_seq_pattern_tx;

    localparam int CLK_DIV  = 4;
    localparam int GAP_BITS = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       stop;
    logic [7:0] pattern;
    logic [2:0] pat_len;
    logic [3:0] rpt;
    logic       bit_out;
    logic       bit_strobe;
    logic       busy;
    logic       done;
    logic [7:0] frame_cnt;
    logic [7:0] seg;

    always #5 clk = ~clk;

    seq_pattern_tx #(.CLK_DIV(CLK_DIV), .GAP_BITS(GAP_BITS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena_i        (ena),
        .start_i      (start),
        .stop_i       (stop),
        .pattern_i    (pattern),
        .pat_len_i    (pat_len),
        .repeat_i     (rpt),
        .bit_out_o    (bit_out),
        .bit_strobe_o (bit_strobe),
        .busy_o       (busy),
        .done_o       (done),
        .frame_cnt_o  (frame_cnt),
        .seg_o        (seg)
    );

    typedef struct packed {
        logic       bo;
        logic       st;
        logic       bz;
        logic       dn;
        logic [7:0] fc;
        logic [7:0] sg;
        logic       sgv;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_bad = 0;

    logic [7:0] sb_fc;
    logic [7:0] sb_pfc;
    logic       sb_pbz;
    bit         sb_first;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        n_chk++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, want, $time);
        end
    endtask

    function automatic logic [7:0] seg_ref(input logic [7:0] fc, input logic bz);
        logic [7:0] dig [10];
        dig = '{8'hFC, 8'hC0, 8'h6E, 8'hE6, 8'hD2, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
        if (!bz && fc == 8'd0) return 8'h02;
        return dig[fc % 10] | {7'd0, bz};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_exp(input logic bo, input logic st, input logic bz, input logic dn);
        exp_t e;
        e.bo  = bo;
        e.st  = st;
        e.bz  = bz;
        e.dn  = dn;
        e.fc  = sb_fc;
        e.sg  = seg_ref(sb_pfc, sb_pbz);
        e.sgv = !sb_first;
        sb_first = 1'b0;
        sb_pfc   = sb_fc;
        sb_pbz   = bz;
        exp_q.push_back(e);
    endtask

    // Expected outputs for cycle 1 onward after a start accepted in cycle 0.
    task automatic push_frames(input logic [7:0] p, input int len, input int nfr, input bit with_done);
        sb_fc    = 8'd0;
        sb_pfc   = 8'd0;
        sb_pbz   = 1'b0;
        sb_first = 1'b1;
        for (int f = 0; f < nfr; f++) begin
            for (int b = len - 1; b >= 0; b--) begin
                for (int c = 0; c < CLK_DIV; c++) begin
                    add_exp(p[b], c == 0, 1'b1, 1'b0);
                end
            end
            sb_fc = sb_fc + 8'd1;
            if (f < nfr - 1) begin
                for (int g = 0; g < GAP_BITS * CLK_DIV; g++) begin
                    add_exp(1'b0, 1'b0, 1'b1, 1'b0);
                end
            end
        end
        if (with_done) begin
            add_exp(1'b0, 1'b0, 1'b0, 1'b1);
            add_exp(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic run_sb(input int max_n, input int ena_a, input int ena_b,
                          input int stop_at, input int poke_at);
        int   k;
        exp_t e;
        k = 0;
        while (exp_q.size() > 0 && k < max_n) begin
            step();
            k++;
            start = (k == poke_at);
            stop  = (k == stop_at);
            ena   = !(k >= ena_a && k <= ena_b);
            if (k == poke_at) begin
                pattern = ~pattern;
                rpt     = 4'd0;
            end
            e = exp_q.pop_front();
            chk($sformatf("bit_out@%0d", k), {7'd0, bit_out}, {7'd0, e.bo});
            chk($sformatf("strobe@%0d", k), {7'd0, bit_strobe}, {7'd0, e.st});
            chk($sformatf("busy@%0d", k), {7'd0, busy}, {7'd0, e.bz});
            chk($sformatf("done@%0d", k), {7'd0, done}, {7'd0, e.dn});
            chk($sformatf("frame_cnt@%0d", k), frame_cnt, e.fc);
            if (e.sgv) chk($sformatf("seg@%0d", k), seg, e.sg);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; stop = 1'b0;
        pattern = 8'h00; pat_len = 3'd0; rpt = 4'd0;

        // Reset values, then idle with start low.
        repeat (3) step();
        chk("rst_bit", {7'd0, bit_out}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_fc", frame_cnt, 8'd0);
        chk("rst_seg", seg, 8'h02);
        rst_n = 1'b1;
        repeat (20) step();
        chk("idle_bit", {7'd0, bit_out}, 8'd0);
        chk("idle_busy", {7'd0, busy}, 8'd0);
        chk("idle_fc", frame_cnt, 8'd0);
        chk("idle_seg", seg, 8'h02);

        // Single "1001" frame.
        pattern = 8'h09; pat_len = 3'd3; rpt = 4'd1;
        push_frames(8'h09, 4, 1, 1'b1);
        start = 1'b1;
        run_sb(1000, 0, -1, 0, 0);

        // ena low in IDLE changes nothing.
        ena = 1'b0;
        repeat (10) step();
        ena = 1'b1;
        step();
        chk("idle_ena_busy", {7'd0, busy}, 8'd0);
        chk("idle_ena_bit", {7'd0, bit_out}, 8'd0);
        chk("idle_ena_fc", frame_cnt, 8'd1);
        chk("idle_ena_seg", seg, 8'hC0);

        // Three frames with gaps.
        pattern = 8'h09; pat_len = 3'd3; rpt = 4'd3;
        push_frames(8'h09, 4, 3, 1'b1);
        start = 1'b1;
        run_sb(1000, 0, -1, 0, 0);
        chk("rep3_seg", seg, 8'hE6);

        // ena low for cycles 6..15 stretches the current bit.
        pattern = 8'h09; pat_len = 3'd3; rpt = 4'd1;
        push_frames(8'h09, 4, 1, 1'b1);
        e = exp_q[5];
        for (int i = 0; i < 10; i++) exp_q.insert(6, e);
        start = 1'b1;
        run_sb(1000, 6, 15, 0, 0);

        // start (with new pattern/repeat) while busy is ignored.
        pattern = 8'h09; pat_len = 3'd3; rpt = 4'd1;
        push_frames(8'h09, 4, 1, 1'b1);
        start = 1'b1;
        run_sb(1000, 0, -1, 0, 8);

        // One-bit pattern.
        pattern = 8'h01; pat_len = 3'd0; rpt = 4'd1;
        push_frames(8'h01, 1, 1, 1'b1);
        start = 1'b1;
        run_sb(1000, 0, -1, 0, 0);

        // Continuous 10100101, stop in cycle 100: two whole frames end by then (cycles 32 and 72).
        pattern = 8'hA5; pat_len = 3'd7; rpt = 4'd0;
        push_frames(8'hA5, 8, 3, 1'b0);
        start = 1'b1;
        run_sb(100, 0, -1, 100, 0);
        exp_q.delete();
        step();
        stop = 1'b0;
        chk("stop_bit", {7'd0, bit_out}, 8'd0);
        chk("stop_busy", {7'd0, busy}, 8'd0);
        chk("stop_done", {7'd0, done}, 8'd0);
        chk("stop_strobe", {7'd0, bit_strobe}, 8'd0);
        chk("stop_fc", frame_cnt, 8'd2);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("stop_nodone%0d", i), {7'd0, done}, 8'd0);
        end
        chk("stop_seg", seg, 8'h6E);

        // start together with stop in IDLE does nothing.
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ss_busy%0d", i), {7'd0, busy}, 8'd0);
            step();
        end
        chk("ss_fc", frame_cnt, 8'd2);

        // Asynchronous reset in the middle of a frame.
        pattern = 8'h09; pat_len = 3'd3; rpt = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("pre_rst_busy", {7'd0, busy}, 8'd1);
        chk("pre_rst_bit", {7'd0, bit_out}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bit", {7'd0, bit_out}, 8'd0);
        chk("arst_busy", {7'd0, busy}, 8'd0);
        chk("arst_strobe", {7'd0, bit_strobe}, 8'd0);
        chk("arst_fc", frame_cnt, 8'd0);
        chk("arst_seg", seg, 8'h02);
        #2 rst_n = 1'b1;
        repeat (10) step();
        chk("post_rst_busy", {7'd0, busy}, 8'd0);
        chk("post_rst_bit", {7'd0, bit_out}, 8'd0);
        chk("post_rst_seg", seg, 8'h02);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
